// File: rtl/perm_rank_engine_pkg.sv
// Shared constants, state encodings and width helpers for the permutation rank/unrank engine.
package perm_rank_engine_pkg;

  localparam int DEF_CLB_N = 5;
  localparam int DEF_CLB_M = 3;
  localparam int DEF_CLB_K = 4;

  localparam logic PRM_RANK   = 1'b0;
  localparam logic PRM_UNRANK = 1'b1;

  typedef enum logic [2:0] {
    PRM_IDLE   = 3'd0,
    PRM_RANKST = 3'd1,
    PRM_DIGIT  = 3'd2,
    PRM_SELECT = 3'd3,
    PRM_DONE   = 3'd4
  } prm_state_e;

  function automatic int fact(input int k);
    int r;
    r = 1;
    for (int i = 2; i <= k; i++) r = r * i;
    return r;
  endfunction

  // Ceiling log2: bits to address x distinct values.
  function automatic int log2(input int x);
    int n;
    n = 0;
    while ((1 << n) < x) n++;
    return n;
  endfunction

  // Bits needed to hold the value x itself.
  function automatic int log2f(input int x);
    int n;
    int v;
    n = 0;
    v = x;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/perm_rank_engine_lehmer.sv
// Lehmer digit helper: counts unused values below a value and finds the digit-th unused value.
module lehmer_digit_unit #(
  parameter int CLB_K = 4,
  parameter int PW    = 3
) (
  input  logic [CLB_K-1:0] used,
  input  logic [PW-1:0]    value,
  input  logic [PW-1:0]    digit,
  output logic [PW-1:0]    below,
  output logic [PW-1:0]    nth
);

  logic [PW:0] seen;

  always_comb begin
    below = '0;
    nth   = '0;
    seen  = '0;
    for (int j = 0; j < CLB_K; j++) begin
      if (!used[j]) begin
        if ((PW+1)'(j) < {1'b0, value}) below = below + 1'b1;
        if (seen == {1'b0, digit}) nth = PW'(j);
        seen = seen + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perm_rank_engine.sv
// Iterative permutation <-> lexicographic rank converter, one element per clock, with error flagging.
module perm_rank_engine
  import perm_rank_engine_pkg::*;
#(
  parameter int CLB_N = DEF_CLB_N,
  parameter int CLB_M = DEF_CLB_M,
  parameter int CLB_K = DEF_CLB_K,
  localparam int PW   = log2(CLB_M + CLB_N),
  localparam int ENW  = log2f(fact(CLB_K))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [PW*CLB_K-1:0] in_prm,
  input  logic [ENW-1:0]      in_enm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_mode,
  output logic [PW*CLB_K-1:0] out_prm,
  output logic [ENW-1:0]      out_enm,
  output logic                out_err
);

  localparam int FACT = fact(CLB_K);

  prm_state_e         state;
  logic [PW-1:0]      idx;
  logic [ENW-1:0]     acc;
  logic [CLB_K-1:0]   used;
  logic [PW-1:0]      prm_q [CLB_K];
  logic [PW-1:0]      dig_q [CLB_K];
  logic               err;
  logic               mode_q;
  logic [ENW-1:0]     enm_q;

  logic [PW-1:0]      cur_val, cur_dig, below, nth, mark_val, rem;
  logic [ENW-1:0]     rank_next, quo;
  logic [CLB_K-1:0]   hit;
  logic               in_range, step_err, last;
  logic [PW*CLB_K-1:0] prm_flat, sel_flat;

  assign in_ready = (state == PRM_IDLE);
  assign last     = (idx == PW'(CLB_K - 1));

  always_comb begin
    cur_val = '0;
    cur_dig = '0;
    for (int j = 0; j < CLB_K; j++) begin
      if (idx == PW'(j)) begin
        cur_val = prm_q[j];
        cur_dig = dig_q[j];
      end
    end
  end

  lehmer_digit_unit #(.CLB_K(CLB_K), .PW(PW)) u_digit (
    .used  (used),
    .value (cur_val),
    .digit (cur_dig),
    .below (below),
    .nth   (nth)
  );

  // Multiplier/divisor is K-idx, a constant per branch, so no general divider is built.
  always_comb begin
    rank_next = '0;
    quo       = '0;
    rem       = '0;
    for (int j = 0; j < CLB_K; j++) begin
      if (idx == PW'(j)) begin
        rank_next = acc * ENW'(CLB_K - j) + ENW'(below);
        quo       = acc / ENW'(CLB_K - j);
        rem       = PW'(acc % ENW'(CLB_K - j));
      end
    end
  end

  always_comb begin
    mark_val = (state == PRM_SELECT) ? nth : cur_val;
    for (int j = 0; j < CLB_K; j++) hit[j] = (mark_val == PW'(j));
    in_range = ({1'b0, cur_val} < (PW+1)'(CLB_K));
    step_err = !in_range || (|(hit & used));
    prm_flat = '0;
    sel_flat = '0;
    for (int j = 0; j < CLB_K; j++) begin
      prm_flat[PW*j +: PW] = prm_q[j];
      sel_flat[PW*j +: PW] = (idx == PW'(j)) ? nth : prm_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRM_IDLE;
      idx       <= '0;
      acc       <= '0;
      used      <= '0;
      err       <= 1'b0;
      mode_q    <= 1'b0;
      enm_q     <= '0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_prm   <= '0;
      out_enm   <= '0;
      out_err   <= 1'b0;
      for (int j = 0; j < CLB_K; j++) begin
        prm_q[j] <= '0;
        dig_q[j] <= '0;
      end
    end else begin
      case (state)
        PRM_IDLE: begin
          if (in_valid) begin
            mode_q <= in_mode;
            enm_q  <= in_enm;
            used   <= '0;
            for (int j = 0; j < CLB_K; j++) prm_q[j] <= in_prm[PW*j +: PW];
            if (in_mode == PRM_UNRANK) begin
              acc   <= in_enm;
              err   <= ({1'b0, in_enm} >= (ENW+1)'(FACT));
              idx   <= PW'(CLB_K - 1);
              state <= PRM_DIGIT;
            end else begin
              acc   <= '0;
              err   <= 1'b0;
              idx   <= '0;
              state <= PRM_RANKST;
            end
          end
        end
        PRM_RANKST: begin
          acc  <= rank_next;
          used <= used | hit;
          err  <= err | step_err;
          if (last) begin
            out_valid <= 1'b1;
            out_mode  <= mode_q;
            out_prm   <= prm_flat;
            out_enm   <= (err | step_err) ? '0 : rank_next;
            out_err   <= err | step_err;
            state     <= PRM_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        PRM_DIGIT: begin
          acc <= quo;
          for (int j = 0; j < CLB_K; j++) if (idx == PW'(j)) dig_q[j] <= rem;
          if (idx == '0) state <= PRM_SELECT;
          else           idx   <= idx - 1'b1;
        end
        PRM_SELECT: begin
          used <= used | hit;
          for (int j = 0; j < CLB_K; j++) if (idx == PW'(j)) prm_q[j] <= nth;
          if (last) begin
            out_valid <= 1'b1;
            out_mode  <= mode_q;
            out_prm   <= err ? '0 : sel_flat;
            out_enm   <= enm_q;
            out_err   <= err;
            state     <= PRM_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        PRM_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= PRM_IDLE;
          end
        end
        default: state <= PRM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_rank_engine.sv
// Scoreboard bench for perm_rank_engine at K=4, M+N=8 (PW=3, ENW=5).
module tb_perm_rank_engine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [11:0] in_prm;
  logic [4:0]  in_enm;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [11:0] out_prm;
  logic [4:0]  out_enm;
  logic        out_err;

  perm_rank_engine #(.CLB_N(5), .CLB_M(3), .CLB_K(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_prm    (in_prm),
    .in_enm    (in_enm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_prm   (out_prm),
    .out_enm   (out_enm),
    .out_err   (out_err)
  );

  typedef struct {
    logic        mode;
    logic [11:0] prm;
    logic [4:0]  enm;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 0;

  // Lexicographic permutations of 0..3, one hex nibble per element p[0..3].
  logic [15:0] tbl [24] = '{
    16'h0123, 16'h0132, 16'h0213, 16'h0231, 16'h0312, 16'h0321,
    16'h1023, 16'h1032, 16'h1203, 16'h1230, 16'h1302, 16'h1320,
    16'h2013, 16'h2031, 16'h2103, 16'h2130, 16'h2301, 16'h2310,
    16'h3012, 16'h3021, 16'h3102, 16'h3120, 16'h3201, 16'h3210
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [11:0] pack(input logic [15:0] h);
    logic [11:0] r;
    for (int i = 0; i < 4; i++) r[3*i +: 3] = h[12-4*i +: 3];
    return r;
  endfunction

  function automatic exp_t mk(input logic m, input logic [11:0] p, input logic [4:0] e,
                              input logic er, input int l);
    exp_t x;
    x.mode = m; x.prm = p; x.enm = e; x.err = er; x.lat = l;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: compare the first cycle of every result window against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n || !out_valid) begin
      seen = 0;
    end else if (!seen) begin
      seen = 1;
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_mode", 32'(out_mode), 32'(e.mode));
        check("out_prm",  32'(out_prm),  32'(e.prm));
        check("out_enm",  32'(out_enm),  32'(e.enm));
        check("out_err",  32'(out_err),  32'(e.err));
        check("latency",  32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic m, input logic [11:0] p, input logic [4:0] e,
                       input exp_t x, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (push) q.push_back(x);
      in_valid = 1'b1;
      in_mode  = m;
      in_prm   = p;
      in_enm   = e;
      @(negedge clk);
      acc_cyc  = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic rank(input logic [15:0] h, input logic [4:0] exp_enm, input logic exp_err);
    issue(1'b0, pack(h), 5'd0, mk(1'b0, pack(h), exp_enm, exp_err, 5), 1'b1);
  endtask

  task automatic unrank(input logic [4:0] e, input logic [11:0] exp_prm, input logic exp_err);
    issue(1'b1, 12'd0, e, mk(1'b1, exp_prm, e, exp_err, 9), 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || !in_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_mode"},  32'(out_mode),  32'd0);
    check({tag, "_out_prm"},   32'(out_prm),   32'd0);
    check({tag, "_out_enm"},   32'(out_enm),   32'd0);
    check({tag, "_out_err"},   32'(out_err),   32'd0);
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_prm    = '0;
    in_enm    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    rank(16'h0123, 5'd0, 1'b0);
    rank(16'h3210, 5'd23, 1'b0);
    rank(16'h1023, 5'd6, 1'b0);
    unrank(5'd6,  pack(16'h1023), 1'b0);
    unrank(5'd23, pack(16'h3210), 1'b0);
    unrank(5'd24, 12'd0, 1'b1);
    rank(16'h1123, 5'd0, 1'b1);
    rank(16'h0125, 5'd0, 1'b1);
    drain();

    for (int i = 0; i < 24; i++) rank(tbl[i], 5'(i), 1'b0);
    for (int i = 0; i < 24; i++) unrank(5'(i), pack(tbl[i]), 1'b0);
    drain();

    // Backpressure: hold the result in DONE for 10 cycles.
    out_ready = 1'b0;
    rank(16'h3210, 5'd23, 1'b0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_enm",   32'(out_enm),   32'd23);
      check("bp_out_prm",   32'(out_prm),   32'(pack(16'h3210)));
      check("bp_out_err",   32'(out_err),   32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    unrank(5'd0, pack(16'h0123), 1'b0);
    drain();

    // Abort a rank request mid-flight; nothing may come out of it.
    issue(1'b0, pack(16'h0123), 5'd0, mk(1'b0, 12'd0, 5'd0, 1'b0, 0), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rank(16'h3210, 5'd23, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
